// File: rtl/adder_tree_pipe_acc_pkg.sv
// Shared helpers for the pipelined adder-tree accumulator.
//   tree_nodes  : node count at a given reduction level (odd nodes pass through)
//   pipe_stages : number of registered tree stages for a given level count
//   sat_add     : 64-bit add with range check against a w-bit signed/unsigned
//                 window, optional clamp to the window limits
package snn_ff_pkg;

  typedef struct packed {
    logic [63:0] val;
    logic        ovf;
  } sat_res_t;

  function automatic int unsigned tree_nodes(int unsigned num, int unsigned level);
    int unsigned n;
    n = num;
    for (int unsigned i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int unsigned pipe_stages(int unsigned levels, int unsigned every);
    return (levels + every - 1) / every;
  endfunction

  // Operands arrive already extended to 64 bits; w must be below 64.
  function automatic sat_res_t sat_add(logic [63:0] a, logic [63:0] b, int unsigned w,
                                       logic is_signed, logic saturate);
    sat_res_t    r;
    logic [63:0] s, mx, mn;
    s = a + b;
    if (is_signed) begin
      mx    = (64'd1 << (w - 1)) - 64'd1;
      mn    = ~mx;
      r.ovf = ($signed(s) > $signed(mx)) || ($signed(s) < $signed(mn));
    end else begin
      mx    = (64'd1 << w) - 64'd1;
      mn    = '0;
      r.ovf = (s > mx);
    end
    r.val = s;
    if (r.ovf && saturate) r.val = (is_signed && s[63]) ? mn : mx;
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_pipe_acc_if.sv
// Beat input / packet output handshake bundle for adder_tree_pipe_acc.
//   in_valid/in_ready/in_data/in_last : beat stream into the tree
//   out_valid/out_ready/out_sum/out_ovf : packet totals out of the accumulator
// master = producer/consumer side, slave = the reduction block.
interface adder_tree_pipe_acc_if #(
  parameter int unsigned NUM       = 16,
  parameter int unsigned IN_WIDTH  = 10,
  parameter int unsigned ACC_WIDTH = IN_WIDTH + $clog2(NUM) + 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM*IN_WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_WIDTH-1:0]    out_sum;
  logic                    out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/adder_tree_pipe_acc_level.sv
// One pairwise-add level of the reduction tree.
//   clk, rst_n      : clock, async active-low reset
//   adv_i           : global pipeline advance
//   valid_i, last_i : beat valid / last-of-packet travelling with the data
//   data_i          : NUM_IN words of W_IN bits
//   valid_o, last_o : delayed (REG=1) or passed-through (REG=0) sideband
//   data_o          : ceil(NUM_IN/2) words of W_IN+1 bits; odd word passes through
module adder_tree_level #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned W_IN   = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned REG    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 adv_i,
  input  logic                                 valid_i,
  input  logic                                 last_i,
  input  logic [NUM_IN*W_IN-1:0]               data_i,
  output logic                                 valid_o,
  output logic                                 last_o,
  output logic [((NUM_IN+1)/2)*(W_IN+1)-1:0]   data_o
);
  localparam int unsigned NUM_OUT = (NUM_IN + 1) / 2;
  localparam int unsigned W_OUT   = W_IN + 1;

  logic [NUM_OUT*W_OUT-1:0] sum_d;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_node
    logic [W_OUT-1:0] a_ext;
    assign a_ext = {(SIGNED != 0) & data_i[2*i*W_IN + W_IN - 1], data_i[2*i*W_IN +: W_IN]};
    if (2*i + 1 < NUM_IN) begin : g_pair
      logic [W_OUT-1:0] b_ext;
      assign b_ext = {(SIGNED != 0) & data_i[(2*i+1)*W_IN + W_IN - 1],
                      data_i[(2*i+1)*W_IN +: W_IN]};
      assign sum_d[i*W_OUT +: W_OUT] = a_ext + b_ext;
    end else begin : g_pass
      assign sum_d[i*W_OUT +: W_OUT] = a_ext;
    end
  end

  if (REG != 0) begin : g_reg
    logic                     valid_q, last_q;
    logic [NUM_OUT*W_OUT-1:0] data_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
      end else if (adv_i) begin
        valid_q <= valid_i;
        last_q  <= last_i;
        data_q  <= sum_d;
      end
    end
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n ^ adv_i;
    assign valid_o    = valid_i;
    assign last_o     = last_i;
    assign data_o     = sum_d;
  end
endmodule

// File: rtl/adder_tree_pipe_acc.sv
// Pipelined reduction tree + packet accumulator for SNN neuron integration.
// Each accepted beat of NUM words is summed exactly by $clog2(NUM) pairwise-add
// levels (registered every PIPE_EVERY levels and on the final level), then added
// into a per-packet accumulator that saturates or wraps at ACC_WIDTH bits.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of adder_tree_pipe_acc_if (beats in, packet totals out)
// The whole pipeline stalls as one unit on output backpressure, so in_ready is
// just the advance signal.
module adder_tree_pipe_acc
  import snn_ff_pkg::*;
#(
  parameter int unsigned NUM        = 16,
  parameter int unsigned IN_WIDTH   = 10,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned PIPE_EVERY = 1,
  parameter int unsigned ACC_WIDTH  = IN_WIDTH + $clog2(NUM) + 6,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_tree_pipe_acc_if.slave bus
);
  localparam int unsigned LEVELS = $clog2(NUM);
  localparam int unsigned TW     = IN_WIDTH + LEVELS;

  logic                 adv;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 first_q, first_d;
  logic                 sticky_q, sticky_d;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  // Level 0 is the raw input; each later level reads the one below it.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned NN = tree_nodes(NUM, l);
    localparam int unsigned W  = IN_WIDTH + l;
    logic [NN*W-1:0] data;
    logic            valid, last;
    if (l == 0) begin : g_src
      assign data  = bus.in_data;
      assign valid = bus.in_valid;
      assign last  = bus.in_last;
    end else begin : g_stage
      adder_tree_level #(
        .NUM_IN (tree_nodes(NUM, l - 1)),
        .W_IN   (W - 1),
        .SIGNED (SIGNED),
        .REG    ((((l % PIPE_EVERY) == 0) || (l == LEVELS)) ? 1 : 0)
      ) u_level (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv),
        .valid_i (g_lvl[l-1].valid),
        .last_i  (g_lvl[l-1].last),
        .data_i  (g_lvl[l-1].data),
        .valid_o (valid),
        .last_o  (last),
        .data_o  (data)
      );
    end
  end

  logic [TW-1:0] tree_sum;
  logic          tree_vld, tree_last;
  logic [63:0]   tree_ext, acc_ext;
  sat_res_t      res;
  logic          unused_hi;

  assign tree_sum  = g_lvl[LEVELS].data;
  assign tree_vld  = g_lvl[LEVELS].valid;
  assign tree_last = g_lvl[LEVELS].last;
  assign tree_ext  = {{(64-TW){(SIGNED != 0) & tree_sum[TW-1]}}, tree_sum};
  assign acc_ext   = {{(64-ACC_WIDTH){(SIGNED != 0) & acc_q[ACC_WIDTH-1]}}, acc_q};
  assign res       = sat_add(first_q ? '0 : acc_ext, tree_ext, ACC_WIDTH,
                             SIGNED != 0, SATURATE != 0);
  assign unused_hi = ^res.val[63:ACC_WIDTH];

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    first_d     = first_q;
    sticky_d    = sticky_q;
    if (adv) begin
      // A held result is consumed on this edge, or there was none; either way
      // the slot reloads only when a last beat leaves the tree.
      out_valid_d = tree_vld && tree_last;
      if (tree_vld) begin
        if (tree_last) begin
          out_sum_d = res.val[ACC_WIDTH-1:0];
          out_ovf_d = sticky_q | res.ovf;
          acc_d     = '0;
          sticky_d  = 1'b0;
          first_d   = 1'b1;
        end else begin
          acc_d     = res.val[ACC_WIDTH-1:0];
          sticky_d  = sticky_q | res.ovf;
          first_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule
